uart_rx_receiver: RTL and testbench



---
 rtl/uart_rx_receiver_pkg.sv | 19 +
 rtl/uart_rx_receiver_rx_fifo.sv | 61 ++++++
 rtl/uart_rx_receiver.sv | 145 ++++++++++++++
 tb/tb_uart_rx_receiver.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_receiver_pkg.sv
// rtl/uart_rx_receiver_pkg.sv - shared UART state encodings and baud divisor formula
package uart_rx_receiver_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Shared with the emitter so both ends derive the bit period identically.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_receiver_rx_fifo.sv
// rtl/uart_rx_receiver_rx_fifo.sv - synchronous first-word-fall-through byte FIFO
module uart_rx_receiver_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign o_full  = (level_q == (AW+1)'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_rdata = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop   = i_pop && !o_empty;
    do_push  = i_push && (!o_full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    level_d = level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/uart_rx_receiver.sv
// rtl/uart_rx_receiver.sv - UART receiver: RXD synchronizer, frame FSM, FIFO and sticky status
module uart_rx_receiver
  import uart_rx_receiver_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          i_rxd,
  output logic [BYTE_W-1:0]             o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_busy,
  output logic                          o_overrun,
  output logic                          o_frame_err,
  input  logic                          i_clr_err
);
  localparam int DIV  = baud_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV) + 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  rx_state_e         state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [1:0]        rdy_q, rdy_d;
  logic              armed_q, armed_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;
  logic              rx_s, push, frame_set;
  logic              fifo_full, fifo_empty;

  always_comb begin
    rx_s      = sync_q[1];
    sync_d    = {sync_q[0], i_rxd};
    // The synchronizer resets to 1, so only a high seen after it has flushed arms start detection.
    rdy_d     = {rdy_q[0], 1'b1};
    armed_d   = armed_q || (rdy_q[1] && rx_s);
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (armed_q && !rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[BYTE_W-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d      = (state_d != ST_IDLE);
    // Set events win over a simultaneous clear.
    overrun_d   = (overrun_q && !i_clr_err) || (push && fifo_full && !i_ready);
    frame_err_d = (frame_err_q && !i_clr_err) || frame_set;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q      <= 2'b11;
      rdy_q       <= '0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rdy_q       <= rdy_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  uart_rx_receiver_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (push),
    .i_wdata (shift_q),
    .i_pop   (i_ready),
    .o_rdata (o_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  assign o_valid     = !fifo_empty;
  assign o_busy      = busy_q;
  assign o_overrun   = overrun_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_receiver.sv
// tb/tb_uart_rx_receiver.sv - randomized self-checking bench for uart_rx_receiver
module tb_uart_rx_receiver;
  localparam int CLK_HZ   = 16;
  localparam int BAUD     = 1;
  localparam int DEPTH    = 4;
  localparam int DIV      = CLK_HZ / BAUD;
  localparam int HALF     = DIV / 2;
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int SYNC_LAG = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          i_rxd = 1'b1;
  logic          i_ready = 1'b0;
  logic          i_clr_err = 1'b0;
  logic [7:0]    o_data;
  logic          o_valid, o_busy, o_overrun, o_frame_err;
  logic [LW-1:0] o_level;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] model_q[$];
  logic       model_ovr = 1'b0;
  logic       model_ferr = 1'b0;

  uart_rx_receiver #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_rxd       (i_rxd),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_level     (o_level),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun),
    .o_frame_err (o_frame_err),
    .i_clr_err   (i_clr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a completed frame either lands in the queue, is dropped as overrun, or flags framing.
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop) model_ferr = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovr = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int hold_low);
    i_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    i_rxd = stop;
    repeat (DIV) @(negedge clk);
    if (!stop) repeat (hold_low) @(negedge clk);
    i_rxd = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic pop_byte(output logic v, output logic [7:0] d);
    v = o_valid;
    d = o_data;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic clear_flags();
    i_clr_err = 1'b1;
    @(negedge clk);
    i_clr_err = 1'b0;
    model_ovr  = 1'b0;
    model_ferr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({o_valid, o_level, o_busy, o_overrun, o_frame_err, o_data} !== {1'b0, LW'(0), 3'b000, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b l=%0d b=%b o=%b f=%b d=%h want all zero", o_valid, o_level, o_busy, o_overrun, o_frame_err, o_data);
    end
    resetn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int n0;
    int seen;
    logic v;
    logic [7:0] d;
    seen = -1;
    n0 = cyc;
    model_frame(8'hA5, 1'b1);
    fork
      send_frame(8'hA5, 1'b1, 0);
      for (int k = 0; k < 300 && seen < 0; k++) begin
        @(negedge clk);
        if (o_valid) seen = cyc - n0;
      end
    join
    vectors++;
    if (seen !== SYNC_LAG + HALF + 9 * DIV + 1) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d cycles want %0d", seen, SYNC_LAG + HALF + 9 * DIV + 1);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if ({o_valid, o_level, o_data, o_overrun, o_frame_err} !== {1'b1, LW'(model_q.size()), model_q[0], model_ovr, model_ferr}) begin
      miscompares++;
      $display("FAIL basic_status: got v=%b l=%0d d=%h o=%b f=%b want v=1 l=1 d=a5 o=0 f=0", o_valid, o_level, o_data, o_overrun, o_frame_err);
    end
    pop_byte(v, d);
    void'(model_q.pop_front());
    vectors++;
    if ({o_valid, o_level} !== {1'b0, LW'(0)}) begin
      miscompares++;
      $display("FAIL basic_pop: got v=%b l=%0d want v=0 l=0", o_valid, o_level);
    end
  endtask

  task automatic test_glitch();
    i_rxd = 1'b0;
    repeat (3) @(negedge clk);
    i_rxd = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_busy: got %b want 1", o_busy);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if ({o_busy, o_valid, o_overrun, o_frame_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL glitch_idle: got b=%b v=%b o=%b f=%b want 0000", o_busy, o_valid, o_overrun, o_frame_err);
    end
  endtask

  task automatic test_frame_err();
    logic v;
    logic [7:0] d;
    model_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0, 40 - DIV);
    repeat (40) @(negedge clk);
    vectors++;
    if ({o_frame_err, o_valid, o_level, o_busy} !== {model_ferr, 1'b0, LW'(0), 1'b0}) begin
      miscompares++;
      $display("FAIL frame_err: got f=%b v=%b l=%0d b=%b want f=1 v=0 l=0 b=0", o_frame_err, o_valid, o_level, o_busy);
    end
    model_frame(8'h11, 1'b1);
    send_frame(8'h11, 1'b1, 0);
    vectors++;
    if ({o_valid, o_level, o_data} !== {1'b1, LW'(model_q.size()), model_q[0]}) begin
      miscompares++;
      $display("FAIL after_break: got v=%b l=%0d d=%h want v=1 l=1 d=11", o_valid, o_level, o_data);
    end
    clear_flags();
    vectors++;
    if (o_frame_err !== model_ferr) begin
      miscompares++;
      $display("FAIL clr_err: got %b want %b", o_frame_err, model_ferr);
    end
    pop_byte(v, d);
    void'(model_q.pop_front());
  endtask

  task automatic test_overrun();
    logic v;
    logic [7:0] d;
    logic [7:0] exp;
    for (int i = 1; i <= 5; i++) begin
      model_frame(8'(i), 1'b1);
      send_frame(8'(i), 1'b1, 0);
    end
    vectors++;
    if ({o_level, o_overrun} !== {LW'(model_q.size()), model_ovr}) begin
      miscompares++;
      $display("FAIL overrun_status: got l=%0d o=%b want l=%0d o=%b", o_level, o_overrun, model_q.size(), model_ovr);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = model_q.pop_front();
      pop_byte(v, d);
      vectors++;
      if ({v, d} !== {1'b1, exp}) begin
        miscompares++;
        $display("FAIL overrun_pop%0d: got v=%b d=%h want v=1 d=%h", i, v, d, exp);
      end
    end
    pop_byte(v, d);
    vectors++;
    if ({v, o_valid, o_level} !== {1'b0, 1'b0, LW'(0)}) begin
      miscompares++;
      $display("FAIL ready_when_empty: got v=%b/%b l=%0d want 0/0 l=0", v, o_valid, o_level);
    end
    clear_flags();
  endtask

  task automatic test_back_to_back();
    logic v;
    logic [7:0] d;
    logic [7:0] b;
    logic [7:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      model_frame(b, 1'b1);
      send_frame(b, 1'b1, 0);
    end
    exp = model_q.pop_front();
    model_frame(8'h55, 1'b1);
    fork
      send_frame(8'h55, 1'b1, 0);
      begin
        repeat (SYNC_LAG + HALF + 9 * DIV) @(negedge clk);
        d = o_data;
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
      end
    join
    vectors++;
    if ({d, o_level, o_overrun} !== {exp, LW'(model_q.size()), model_ovr}) begin
      miscompares++;
      $display("FAIL full_push_pop: got d=%h l=%0d o=%b want d=%h l=%0d o=%b", d, o_level, o_overrun, exp, model_q.size(), model_ovr);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = model_q.pop_front();
      pop_byte(v, d);
      vectors++;
      if ({v, d} !== {1'b1, exp}) begin
        miscompares++;
        $display("FAIL wrap_pop%0d: got v=%b d=%h want v=1 d=%h", i, v, d, exp);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic v;
    logic [7:0] d;
    model_frame(8'h9C, 1'b1);
    send_frame(8'h9C, 1'b1, 0);
    fork
      send_frame(8'h0F, 1'b1, 0);
      begin
        repeat (DIV + 4 * DIV + HALF) @(negedge clk);
        resetn = 1'b0;
        model_q.delete();
        model_ovr  = 1'b0;
        model_ferr = 1'b0;
        #1;
        vectors++;
        if ({o_valid, o_level, o_busy, o_overrun, o_frame_err, o_data} !== {1'b0, LW'(0), 3'b000, 8'h00}) begin
          miscompares++;
          $display("FAIL reset_async: got v=%b l=%0d b=%b o=%b f=%b d=%h want all zero", o_valid, o_level, o_busy, o_overrun, o_frame_err, o_data);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    vectors++;
    if ({o_valid, o_level, o_busy} !== {1'b0, LW'(0), 1'b0}) begin
      miscompares++;
      $display("FAIL reset_no_partial: got v=%b l=%0d b=%b want 0/0/0", o_valid, o_level, o_busy);
    end
    model_frame(8'h7E, 1'b1);
    send_frame(8'h7E, 1'b1, 0);
    vectors++;
    if ({o_level, o_data} !== {LW'(model_q.size()), model_q[0]}) begin
      miscompares++;
      $display("FAIL reset_then_7e: got l=%0d d=%h want l=1 d=7e", o_level, o_data);
    end
    pop_byte(v, d);
    void'(model_q.pop_front());
  endtask

  task automatic test_random();
    logic v;
    logic [7:0] d;
    logic [7:0] b;
    logic [7:0] exp;
    logic stop;
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      model_frame(b, stop);
      send_frame(b, stop, int'($urandom_range(0, 20)));
      vectors++;
      if ({o_level, o_overrun, o_frame_err} !== {LW'(model_q.size()), model_ovr, model_ferr}) begin
        miscompares++;
        $display("FAIL rand%0d_status: got l=%0d o=%b f=%b want l=%0d o=%b f=%b", n, o_level, o_overrun, o_frame_err, model_q.size(), model_ovr, model_ferr);
      end
      if (model_q.size() != 0 && $urandom_range(0, 1) == 1) begin
        exp = model_q.pop_front();
        pop_byte(v, d);
        vectors++;
        if ({v, d} !== {1'b1, exp}) begin
          miscompares++;
          $display("FAIL rand%0d_pop: got v=%b d=%h want v=1 d=%h", n, v, d, exp);
        end
      end
      if ($urandom_range(0, 4) == 0) clear_flags();
    end
    while (model_q.size() != 0) begin
      exp = model_q.pop_front();
      pop_byte(v, d);
      vectors++;
      if ({v, d} !== {1'b1, exp}) begin
        miscompares++;
        $display("FAIL rand_drain: got v=%b d=%h want v=1 d=%h", v, d, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
